// File: rtl/channel_scanner.sv
// rtl/channel_scanner.sv - sequential select-line scanner for a 4-to-1 selector with dwell, capture and sweep control
// Optional build macro SCANNER_HOLD_LAST_EN: keep the last driven channel on oS1:oS0 after returning to IDLE.
module channel_scanner #(
    parameter int DWELL_W = 8
) (
    input  logic               iClk,
    input  logic               iRst,
    input  logic               iStart,
    input  logic               iStop,
    input  logic               iMode,
    input  logic [3:0]         iMask,
    input  logic [DWELL_W-1:0] iDwell,
    input  logic [3:0]         iZ,
    output logic               oS0,
    output logic               oS1,
    output logic               oBusy,
    output logic               oValid,
    output logic [1:0]         oCh,
    output logic [3:0]         oData,
    output logic               oDone
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

`ifdef SCANNER_HOLD_LAST_EN
    localparam bit HOLD_LAST = 1'b1;
`else
    localparam bit HOLD_LAST = 1'b0;
`endif

    state_t             state_q;
    logic               mode_q;
    logic [3:0]         mask_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [DWELL_W-1:0] cnt_q;
    logic [1:0]         sel_q;
    logic               valid_q;
    logic               done_q;
    logic [1:0]         ch_q;
    logic [3:0]         data_q;

    logic [1:0]         first_sel_d;
    logic [1:0]         next_sel_d;
    logic [1:0]         idle_sel_d;
    logic               sweep_last_d;

    function automatic logic [1:0] lowest_en(input logic [3:0] m);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) r = 2'(i);
        end
        return r;
    endfunction

    function automatic logic [1:0] highest_en(input logic [3:0] m);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) r = 2'(i);
        end
        return r;
    endfunction

    // Nearest enabled channel above cur, wrapping 3 to 0; cur itself if it is the only one.
    function automatic logic [1:0] next_en(input logic [3:0] m, input logic [1:0] cur);
        logic [1:0] r;
        logic [1:0] c;
        r = cur;
        for (int off = 3; off >= 1; off--) begin
            c = cur + 2'(off);
            if (m[c]) r = c;
        end
        return r;
    endfunction

    always_comb begin
        first_sel_d  = lowest_en(iMask);
        next_sel_d   = next_en(mask_q, sel_q);
        sweep_last_d = (sel_q == highest_en(mask_q));
        idle_sel_d   = HOLD_LAST ? sel_q : 2'b00;
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            mask_q  <= 4'd0;
            dwell_q <= '0;
            cnt_q   <= '0;
            sel_q   <= 2'd0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            ch_q    <= 2'd0;
            data_q  <= 4'd0;
        end else begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (iStart && !iStop) begin
                        if (iMask != 4'd0) begin
                            state_q <= SCAN;
                            mode_q  <= iMode;
                            mask_q  <= iMask;
                            dwell_q <= iDwell;
                            cnt_q   <= iDwell;
                            sel_q   <= first_sel_d;
                        end else begin
                            done_q  <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    // Stop takes priority over a dwell expiry in the same cycle.
                    if (iStop) begin
                        state_q <= IDLE;
                        sel_q   <= idle_sel_d;
                    end else if (cnt_q != '0) begin
                        cnt_q   <= cnt_q - 1'b1;
                    end else begin
                        valid_q <= 1'b1;
                        ch_q    <= sel_q;
                        data_q  <= iZ;
                        cnt_q   <= dwell_q;
                        if (!mode_q && sweep_last_d) begin
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                            sel_q   <= idle_sel_d;
                        end else begin
                            sel_q   <= next_sel_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign oS0    = sel_q[0];
    assign oS1    = sel_q[1];
    assign oBusy  = (state_q == SCAN);
    assign oValid = valid_q;
    assign oDone  = done_q;
    assign oCh    = ch_q;
    assign oData  = data_q;

endmodule

// File: tb/tb_channel_scanner.sv
// tb/tb_channel_scanner.sv - self-checking bench for channel_scanner with a selector model and sweep reference model
module tb_channel_scanner;

`ifdef SCANNER_HOLD_LAST_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic       iClk;
    logic       iRst;
    logic       iStart;
    logic       iStop;
    logic       iMode;
    logic [3:0] iMask;
    logic [7:0] iDwell;
    logic [3:0] iZ;
    logic       oS0;
    logic       oS1;
    logic       oBusy;
    logic       oValid;
    logic [1:0] oCh;
    logic [3:0] oData;
    logic       oDone;

    int checks;
    int failures;

    logic [1:0] hold_s;
    logic [1:0] m_ch;
    logic [3:0] m_data;

    channel_scanner #(.DWELL_W(8)) dut (
        .iClk   (iClk),
        .iRst   (iRst),
        .iStart (iStart),
        .iStop  (iStop),
        .iMode  (iMode),
        .iMask  (iMask),
        .iDwell (iDwell),
        .iZ     (iZ),
        .oS0    (oS0),
        .oS1    (oS1),
        .oBusy  (oBusy),
        .oValid (oValid),
        .oCh    (oCh),
        .oData  (oData),
        .oDone  (oDone)
    );

    function automatic logic [3:0] cval(input logic [1:0] ch);
        case (ch)
            2'd0:    return 4'b0001;
            2'd1:    return 4'b0011;
            2'd2:    return 4'b0111;
            default: return 4'b1111;
        endcase
    endfunction

    always_comb iZ = cval({oS1, oS0});

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_s"}, {oS1, oS0}, 0);
        chk({name, "_busy"}, oBusy, 0);
        chk({name, "_valid"}, oValid, 0);
        chk({name, "_done"}, oDone, 0);
        chk({name, "_ch"}, oCh, 0);
        chk({name, "_data"}, oData, 0);
    endtask

    // Start a scan at the current sample point and follow it cycle by cycle.
    // Cycle k is observed just after edge E0+k; channel j of the enabled list owns
    // cycles j*(D+1) .. j*(D+1)+D and its strobe appears after edge (j+1)*(D+1).
    task automatic run_scan(input logic [3:0] mask, input int dwell, input logic mode,
                            input int stop_at, output int n_strobes, output int n_busy);
        int list[$];
        int n, p, stop_edge, busy_end;
        logic exp_busy, exp_valid, exp_done;
        logic [1:0] exp_s;
        for (int c = 0; c < 4; c++) if (mask[c]) list.push_back(c);
        n = list.size();
        p = dwell + 1;
        stop_edge = (stop_at >= 0) ? stop_at + 1 : 32'h3fff_ffff;
        busy_end = mode ? stop_edge : ((n * p < stop_edge) ? n * p : stop_edge);
        n_strobes = 0;
        n_busy = 0;
        iStart = 1'b1; iStop = 1'b0; iMode = mode; iMask = mask; iDwell = 8'(dwell);
        for (int k = 0; k <= busy_end + 1; k++) begin
            @(posedge iClk); #1;
            exp_busy  = (k < busy_end);
            exp_valid = (k >= 1) && (k % p == 0) && (k < stop_edge) && (mode || k <= n * p);
            exp_done  = !mode && (k == n * p) && (k < stop_edge);
            if (exp_valid) begin
                m_ch   = 2'(list[(k / p - 1) % n]);
                m_data = cval(m_ch);
            end
            if (exp_busy) begin
                exp_s  = 2'(list[(k / p) % n]);
                hold_s = exp_s;
            end else begin
                exp_s = HOLD ? hold_s : 2'd0;
            end
            chk("scan_busy", oBusy, exp_busy);
            chk("scan_valid", oValid, exp_valid);
            chk("scan_done", oDone, exp_done);
            chk("scan_ch", oCh, m_ch);
            chk("scan_data", oData, m_data);
            chk("scan_sel", {oS1, oS0}, exp_s);
            n_strobes += int'(oValid);
            n_busy += int'(oBusy);
            iStop = (k == stop_at);
            if (k < busy_end) begin
                iStart = 1'($urandom);
                iMask  = 4'($urandom);
                iDwell = 8'($urandom);
                iMode  = 1'($urandom);
            end else begin
                iStart = 1'b0;
            end
        end
        iStart = 1'b0;
        iStop  = 1'b0;
    endtask

    typedef struct {
        logic [3:0] mask;
        int         dwell;
        logic       mode;
        int         stop_at;
        int         exp_strobes;
        int         exp_busy;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int ns, nb, n, p, st;
        logic [3:0] rm;
        logic rmode;
        int rd;
        checks = 0;
        failures = 0;
        hold_s = 2'd0;
        m_ch = 2'd0;
        m_data = 4'd0;
        iRst = 1'b1; iStart = 1'b0; iStop = 1'b0; iMode = 1'b0; iMask = 4'd0; iDwell = 8'd0;

        tbl[0] = '{4'b1111, 3, 1'b0, -1, 4, 16};
        tbl[1] = '{4'b1010, 0, 1'b0, -1, 2, 2};
        tbl[2] = '{4'b0101, 2, 1'b1, 30, 10, 31};
        tbl[3] = '{4'b0100, 5, 1'b0, -1, 1, 6};
        tbl[4] = '{4'b1000, 0, 1'b0, -1, 1, 1};
        tbl[5] = '{4'b1111, 0, 1'b0, -1, 4, 4};
        tbl[6] = '{4'b1111, 3, 1'b0, 5, 1, 6};
        tbl[7] = '{4'b0011, 1, 1'b1, 3, 1, 4};

        repeat (2) @(posedge iClk);
        #1;
        chk_all_zero("reset");
        iRst = 1'b0;
        @(posedge iClk); #1;
        chk_all_zero("post_reset");

        for (int i = 0; i < 8; i++) begin
            run_scan(tbl[i].mask, tbl[i].dwell, tbl[i].mode, tbl[i].stop_at, ns, nb);
            chk($sformatf("vec%0d_strobes", i), ns, tbl[i].exp_strobes);
            chk($sformatf("vec%0d_busy_cycles", i), nb, tbl[i].exp_busy);
        end

        // Empty mask: done pulse only.
        iStart = 1'b1; iMask = 4'd0;
        @(posedge iClk); #1;
        chk("empty_done", oDone, 1);
        chk("empty_busy", oBusy, 0);
        chk("empty_valid", oValid, 0);
        chk("empty_ch", oCh, m_ch);
        chk("empty_sel", {oS1, oS0}, HOLD ? hold_s : 2'd0);
        iStart = 1'b0;
        @(posedge iClk); #1;
        chk("empty_done_clear", oDone, 0);

        // Start and stop together in IDLE: no response.
        iStart = 1'b1; iStop = 1'b1; iMask = 4'b1111;
        @(posedge iClk); #1;
        chk("startstop_busy", oBusy, 0);
        chk("startstop_done", oDone, 0);
        chk("startstop_valid", oValid, 0);
        iStart = 1'b0; iStop = 1'b0;
        @(posedge iClk); #1;
        chk("startstop_busy2", oBusy, 0);

        // Reset in the middle of channel 2's dwell, then a clean restart.
        iStart = 1'b1; iMask = 4'b0111; iDwell = 8'd3; iMode = 1'b0;
        @(posedge iClk); #1;
        iStart = 1'b0;
        repeat (9) @(posedge iClk);
        #1;
        chk("rst_pre_sel", {oS1, oS0}, 2);
        chk("rst_pre_busy", oBusy, 1);
        #2;
        iRst = 1'b1;
        #1;
        chk_all_zero("rst_async");
        @(posedge iClk); #1;
        chk_all_zero("rst_held");
        iRst = 1'b0;
        hold_s = 2'd0; m_ch = 2'd0; m_data = 4'd0;
        run_scan(4'b0110, 1, 1'b0, -1, ns, nb);
        chk("restart_strobes", ns, 2);

        // Randomized sweeps against the reference model.
        for (int r = 0; r < 30; r++) begin
            rm = 4'($urandom_range(1, 15));
            rd = $urandom_range(0, 4);
            rmode = 1'($urandom);
            n = 0;
            for (int c = 0; c < 4; c++) n += int'(rm[c]);
            p = rd + 1;
            if (rmode) st = $urandom_range(0, 3 * n * p);
            else st = ($urandom_range(0, 1) == 0) ? -1 : $urandom_range(0, n * p - 1);
            run_scan(rm, rd, rmode, st, ns, nb);
            repeat ($urandom_range(0, 3)) begin
                @(posedge iClk); #1;
                chk("gap_busy", oBusy, 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
